// File: rtl/spi_stream_pkg.sv
// Shared types and constants for the streaming SPI slave.
package spi_stream_pkg;

  // One synchronised pin: its settled level plus single-cycle edge strobes.
  typedef struct packed {
    logic rise;
    logic fall;
    logic level;
  } sync_edge_t;

  // Frame-level state: the slave is either waiting for CS or inside a frame.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } frame_state_t;

  // Word shifted out when the upstream side has nothing to send, and the
  // value shifted into the tx register behind the outgoing bits.
  localparam logic [31:0] SPI_IDLE_FILL = 32'hFFFF_FFFF;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with rise/fall strobes
// taken from the last two stages of the chain.
module spi_sync_edge
  import spi_stream_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       pin,
  output sync_edge_t det
);

  // The chain is one flop longer than the synchroniser so the edge detector
  // compares two already-settled stages.
  localparam int CHAIN_W = SYNC_STAGES + 1;

  logic [CHAIN_W-1:0] chain_q;

  // Shift the pin into the synchroniser chain; reset to the pin's idle level
  // so no false edge appears when reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_q <= {CHAIN_W{RESET_VAL}};
    end else begin
      chain_q <= {chain_q[CHAIN_W-2:0], pin};
    end
  end

  // Settled level and edge strobes from the last two stages.
  always_comb begin
    det       = '0;
    det.level = chain_q[CHAIN_W-2];
    det.rise  = chain_q[CHAIN_W-2] & ~chain_q[CHAIN_W-1];
    det.fall  = ~chain_q[CHAIN_W-2] & chain_q[CHAIN_W-1];
  end

endmodule

// File: rtl/spi_slave_stream.sv
// Parametrised SPI slave with word-level valid/ready streaming, fully in the
// clk domain. sck, cs_n and mosi are oversampled; any CPOL/CPHA mode and any
// word width from 4 to 32 bits; multiple words per CS assertion.
module spi_slave_stream
  import spi_stream_pkg::*;
#(
  parameter int WORD_W      = 16,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_active,
  output logic [CNT_W-1:0]  word_count,
  output logic              tx_underrun,
  output logic              frame_abort
);

  // Handshake: tx_valid is looked at only in a load cycle; the load consumes
  // tx_data and pulses tx_ready, or shifts out idle fill and pulses
  // tx_underrun if tx_valid is low. rx_valid pulses for exactly one cycle
  // when rx_data takes a new word; there is no backpressure on rx.

  localparam int                BIT_W    = $clog2(WORD_W);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic              SCK_IDLE = (CPOL != 0);
  localparam logic              LATE_CAP = (CPHA != 0);

  sync_edge_t sck_det;
  sync_edge_t cs_det;
  sync_edge_t mosi_det;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(SCK_IDLE)) u_sync_sck (
    .clk   (clk),
    .reset (reset),
    .pin   (sck),
    .det   (sck_det)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk   (clk),
    .reset (reset),
    .pin   (cs_n),
    .det   (cs_det)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .reset (reset),
    .pin   (mosi),
    .det   (mosi_det)
  );

  // Only the mosi level, the sck edges and the cs edges are used.
  logic unused_sync_bits;
  assign unused_sync_bits = &{1'b0, sck_det.level, cs_det.level,
                              mosi_det.rise, mosi_det.fall};

  frame_state_t state_q, state_d;

  logic [BIT_W-1:0]  bit_cnt_q;
  logic [WORD_W-1:0] rx_shift_q;
  logic [WORD_W-1:0] tx_shift_q;
  logic [WORD_W-1:0] rx_data_q;
  logic [CNT_W-1:0]  word_count_q;
  logic              rx_valid_q;
  logic              tx_ready_q;
  logic              tx_underrun_q;
  logic              frame_abort_q;
  logic              skip_q;
  logic              load_pend_q;

  logic              cs_start;
  logic              cs_stop;
  logic              sck_ok;
  logic              lead_ev;
  logic              trail_ev;
  logic              sample_ev;
  logic              shift_ev;
  logic              word_done;
  logic              load_now;
  logic              shift_now;
  logic [WORD_W-1:0] load_word;
  logic [WORD_W-1:0] rx_next;

  // Frame state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame next-state: CS falling opens a frame, CS rising closes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cs_det.fall) state_d = ST_ACTIVE;
      ST_ACTIVE: if (cs_det.rise) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Event decode: CS edges win over any sck edge seen in the same cycle, and
  // sck edges only count inside a frame.
  always_comb begin
    cs_start  = (state_q == ST_IDLE) && cs_det.fall;
    cs_stop   = (state_q == ST_ACTIVE) && cs_det.rise;
    sck_ok    = (state_q == ST_ACTIVE) && !cs_det.rise && !cs_det.fall;
    lead_ev   = sck_ok && (SCK_IDLE ? sck_det.fall : sck_det.rise);
    trail_ev  = sck_ok && (SCK_IDLE ? sck_det.rise : sck_det.fall);
    sample_ev = LATE_CAP ? trail_ev : lead_ev;
    shift_ev  = LATE_CAP ? lead_ev : trail_ev;
    word_done = sample_ev && (bit_cnt_q == LAST_BIT);
    // CPHA=1 reloads on the completing sample edge; CPHA=0 defers the reload
    // to the following shift edge so the last bit stays on miso until then.
    load_now  = cs_start
              || (LATE_CAP && word_done)
              || (!LATE_CAP && shift_ev && load_pend_q);
    shift_now = shift_ev && (LATE_CAP ? !skip_q : !load_pend_q);
    load_word = tx_valid ? tx_data : SPI_IDLE_FILL[WORD_W-1:0];
    rx_next   = {rx_shift_q[WORD_W-2:0], mosi_det.level};
  end

  // Shift registers, counters, flags and the single-cycle status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      rx_data_q     <= '0;
      word_count_q  <= '0;
      rx_valid_q    <= 1'b0;
      tx_ready_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_abort_q <= 1'b0;
      skip_q        <= 1'b0;
      load_pend_q   <= 1'b0;
    end else begin
      rx_valid_q    <= 1'b0;
      tx_ready_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_abort_q <= 1'b0;

      if (load_now) begin
        tx_shift_q    <= load_word;
        tx_ready_q    <= tx_valid;
        tx_underrun_q <= !tx_valid;
      end else if (shift_now) begin
        tx_shift_q <= {tx_shift_q[WORD_W-2:0], 1'b1};
      end

      if (cs_start) begin
        bit_cnt_q    <= '0;
        word_count_q <= '0;
        skip_q       <= LATE_CAP;
        load_pend_q  <= 1'b0;
      end else if (cs_stop) begin
        // A partial word is dropped; rx_data keeps the last complete word.
        frame_abort_q <= (bit_cnt_q != '0);
        bit_cnt_q     <= '0;
        skip_q        <= 1'b0;
        load_pend_q   <= 1'b0;
      end else begin
        if (sample_ev) begin
          rx_shift_q <= rx_next;
          if (word_done) begin
            bit_cnt_q  <= '0;
            rx_data_q  <= rx_next;
            rx_valid_q <= 1'b1;
            if (word_count_q != CNT_MAX) begin
              word_count_q <= word_count_q + CNT_W'(1);
            end
            if (LATE_CAP) begin
              skip_q <= 1'b1;
            end else begin
              load_pend_q <= 1'b1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          end
        end
        if (shift_ev) begin
          if (LATE_CAP) begin
            skip_q <= 1'b0;
          end else begin
            load_pend_q <= 1'b0;
          end
        end
      end
    end
  end

  // frame_active mirrors the frame state; miso idles high outside a frame.
  assign frame_active = (state_q == ST_ACTIVE);
  assign miso_oe      = (state_q == ST_ACTIVE);
  assign miso         = (state_q == ST_ACTIVE) ? tx_shift_q[WORD_W-1] : 1'b1;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign tx_ready     = tx_ready_q;
  assign tx_underrun  = tx_underrun_q;
  assign frame_abort  = frame_abort_q;
  assign word_count   = word_count_q;

endmodule

// File: tb/tb_spi_slave_stream.sv
// Directed bench for spi_slave_stream: four instances (mode 0, mode 1 with a
// 2-bit word counter, mode 2 with 8-bit words, mode 3) share sck, mosi, reset
// and the tx stream; each has its own cs_n, and one bus master task drives
// whichever instance is selected.
module tb_spi_slave_stream;

  localparam int H = 10;  // sck half period in clk cycles

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        sck;
  logic        mosi;
  logic [3:0]  cs_n_v;
  logic [15:0] tx_data;
  logic        tx_valid;

  // ---------------- per-instance outputs ----------------
  logic [3:0]  miso_v, oe_v, txr_v, rxv_v, und_v, abt_v, act_v;
  logic [15:0] rxd0, rxd1, rxd3;
  logic [7:0]  rxd2;
  logic [7:0]  wc0, wc2, wc3;
  logic [1:0]  wc1;

  spi_slave_stream #(.WORD_W(16), .CPOL(0), .CPHA(0), .SYNC_STAGES(2), .CNT_W(8)) u_m0 (
    .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n_v[0]), .mosi(mosi),
    .miso(miso_v[0]), .miso_oe(oe_v[0]), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(txr_v[0]), .rx_data(rxd0), .rx_valid(rxv_v[0]), .frame_active(act_v[0]),
    .word_count(wc0), .tx_underrun(und_v[0]), .frame_abort(abt_v[0])
  );

  spi_slave_stream #(.WORD_W(16), .CPOL(0), .CPHA(1), .SYNC_STAGES(2), .CNT_W(2)) u_m1 (
    .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n_v[1]), .mosi(mosi),
    .miso(miso_v[1]), .miso_oe(oe_v[1]), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(txr_v[1]), .rx_data(rxd1), .rx_valid(rxv_v[1]), .frame_active(act_v[1]),
    .word_count(wc1), .tx_underrun(und_v[1]), .frame_abort(abt_v[1])
  );

  spi_slave_stream #(.WORD_W(8), .CPOL(1), .CPHA(0), .SYNC_STAGES(2), .CNT_W(8)) u_m2 (
    .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n_v[2]), .mosi(mosi),
    .miso(miso_v[2]), .miso_oe(oe_v[2]), .tx_data(tx_data[7:0]), .tx_valid(tx_valid),
    .tx_ready(txr_v[2]), .rx_data(rxd2), .rx_valid(rxv_v[2]), .frame_active(act_v[2]),
    .word_count(wc2), .tx_underrun(und_v[2]), .frame_abort(abt_v[2])
  );

  spi_slave_stream #(.WORD_W(16), .CPOL(1), .CPHA(1), .SYNC_STAGES(2), .CNT_W(8)) u_m3 (
    .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n_v[3]), .mosi(mosi),
    .miso(miso_v[3]), .miso_oe(oe_v[3]), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(txr_v[3]), .rx_data(rxd3), .rx_valid(rxv_v[3]), .frame_active(act_v[3]),
    .word_count(wc3), .tx_underrun(und_v[3]), .frame_abort(abt_v[3])
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  logic [15:0] tx_q[$];
  int rxv_cnt [4];
  int txr_cnt [4];
  int und_cnt [4];
  int abt_cnt [4];
  int n_total;
  int n_bad;
  int sel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse counters and received-word capture, sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rxv_v[i]) rxv_cnt[i]++;
      if (txr_v[i]) txr_cnt[i]++;
      if (und_v[i]) und_cnt[i]++;
      if (abt_v[i]) abt_cnt[i]++;
    end
    if (rxv_v[0]) obs_q.push_back(rxd0);
    if (rxv_v[1]) obs_q.push_back(rxd1);
    if (rxv_v[2]) obs_q.push_back({8'h00, rxd2});
    if (rxv_v[3]) obs_q.push_back(rxd3);
  end

  // Upstream tx source: the queue front is on tx_data; a tx_ready pops it.
  always @(negedge clk) begin
    if ((|txr_v) && (tx_q.size() != 0)) void'(tx_q.pop_front());
    tx_valid = (tx_q.size() != 0);
    tx_data  = (tx_q.size() != 0) ? tx_q[0] : 16'h0000;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_begin(input int idx, input logic cpol);
    sel = idx;
    sck = cpol;
    wait_clk(4);
    cs_n_v[idx] = 1'b0;
    wait_clk(2 * H);
  endtask

  task automatic frame_end(input int idx);
    wait_clk(H);
    cs_n_v[idx] = 1'b1;
    wait_clk(2 * H);
  endtask

  // Master side of one word, MSB first; returns the bits seen on miso.
  task automatic spi_word(input logic cpol, input logic cpha, input int nbits,
                          input logic [31:0] txw, output logic [31:0] rxw);
    rxw = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      if (!cpha) begin
        mosi = txw[i];
        wait_clk(H);
        rxw = {rxw[30:0], miso_v[sel]};
        sck = ~cpol;
        wait_clk(H);
        sck = cpol;
      end else begin
        wait_clk(H);
        sck = ~cpol;
        mosi = txw[i];
        wait_clk(H);
        rxw = {rxw[30:0], miso_v[sel]};
        sck = cpol;
      end
    end
  endtask

  task automatic drain_rx(input string tag);
    logic [15:0] e;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_present"}, 32'(obs_q.size() != 0), 32'd1);
      if (obs_q.size() != 0) check(tag, obs_q.pop_front(), e);
    end
    check({tag, "_extra"}, obs_q.size(), 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin : main
    logic [31:0] r;
    int s_rxv, s_txr, s_und, s_abt;
    logic [15:0] w5 [5];

    w5[0] = 16'h0102; w5[1] = 16'hF00D; w5[2] = 16'h8001;
    w5[3] = 16'h7FFE; w5[4] = 16'hC0DE;
    n_total = 0;
    n_bad   = 0;
    sel     = 0;
    reset   = 1'b1;
    sck     = 1'b0;
    mosi    = 1'b0;
    cs_n_v  = 4'hF;
    wait_clk(5);

    // Reset state.
    check("rst_miso", miso_v[0], 1);
    check("rst_oe", oe_v[0], 0);
    check("rst_rx_data", rxd0, 0);
    check("rst_active", act_v, 0);
    check("rst_wc", wc0, 0);
    check("rst_pulses", {txr_v, rxv_v, und_v, abt_v}, 0);
    reset = 1'b0;
    wait_clk(5);

    // Mode 0 single word: receive A5C3, transmit 1234.
    s_rxv = rxv_cnt[0]; s_txr = txr_cnt[0]; s_und = und_cnt[0];
    tx_q.push_back(16'h1234);
    exp_q.push_back(16'hA5C3);
    frame_begin(0, 1'b0);
    check("m0_active", act_v[0], 1);
    check("m0_oe", oe_v[0], 1);
    spi_word(1'b0, 1'b0, 16, 32'hA5C3, r);
    frame_end(0);
    check("m0_miso_word", r, 32'h1234);
    check("m0_rx_data", rxd0, 16'hA5C3);
    drain_rx("m0_rx");
    check("m0_rxv_pulses", rxv_cnt[0] - s_rxv, 1);
    check("m0_tx_ready", txr_cnt[0] - s_txr, 1);
    // The trailing edge after the last bit reloads with nothing queued.
    check("m0_underrun", und_cnt[0] - s_und, 1);
    check("m0_wc", wc0, 1);
    check("m0_idle_miso", miso_v[0], 1);
    check("m0_idle_oe", oe_v[0], 0);
    check("m0_idle_active", act_v[0], 0);

    // Mode 3, three words back to back.
    s_rxv = rxv_cnt[3]; s_txr = txr_cnt[3]; s_und = und_cnt[3];
    tx_q.push_back(16'h0001); tx_q.push_back(16'h8000); tx_q.push_back(16'hFFFE);
    exp_q.push_back(16'h1111); exp_q.push_back(16'h2222); exp_q.push_back(16'h3333);
    frame_begin(3, 1'b1);
    spi_word(1'b1, 1'b1, 16, 32'h1111, r);
    check("m3_miso_w0", r, 32'h0001);
    spi_word(1'b1, 1'b1, 16, 32'h2222, r);
    check("m3_miso_w1", r, 32'h8000);
    spi_word(1'b1, 1'b1, 16, 32'h3333, r);
    check("m3_miso_w2", r, 32'hFFFE);
    frame_end(3);
    drain_rx("m3_rx");
    check("m3_rxv_pulses", rxv_cnt[3] - s_rxv, 3);
    check("m3_tx_ready", txr_cnt[3] - s_txr, 3);
    check("m3_underrun", und_cnt[3] - s_und, 1);
    check("m3_wc", wc3, 3);

    // Mode 1 underrun at frame start; a word queued later feeds the next load.
    s_rxv = rxv_cnt[1]; s_txr = txr_cnt[1]; s_und = und_cnt[1];
    exp_q.push_back(16'h6B2D);
    frame_begin(1, 1'b0);
    tx_q.push_back(16'h7777);
    spi_word(1'b0, 1'b1, 16, 32'h6B2D, r);
    frame_end(1);
    check("m1_miso_fill", r, 32'hFFFF);
    drain_rx("m1_rx");
    check("m1_underrun", und_cnt[1] - s_und, 1);
    check("m1_tx_ready", txr_cnt[1] - s_txr, 1);
    check("m1_rxv_pulses", rxv_cnt[1] - s_rxv, 1);
    check("m1_wc", wc1, 1);

    // Abort after 5 bits on mode 0, then a normal frame.
    s_rxv = rxv_cnt[0]; s_abt = abt_cnt[0];
    tx_q.push_back(16'h0F0F);
    frame_begin(0, 1'b0);
    spi_word(1'b0, 1'b0, 5, 32'h13, r);
    frame_end(0);
    check("ab_miso_bits", r, 32'h01);
    check("ab_abort", abt_cnt[0] - s_abt, 1);
    check("ab_no_rxv", rxv_cnt[0] - s_rxv, 0);
    check("ab_rx_kept", rxd0, 16'hA5C3);
    check("ab_wc", wc0, 0);
    drain_rx("ab_rx");
    tx_q.delete();
    tx_q.push_back(16'hBEEF);
    exp_q.push_back(16'h3C5A);
    frame_begin(0, 1'b0);
    spi_word(1'b0, 1'b0, 16, 32'h3C5A, r);
    frame_end(0);
    check("ab2_miso_word", r, 32'hBEEF);
    check("ab2_rx_data", rxd0, 16'h3C5A);
    check("ab2_wc", wc0, 1);
    drain_rx("ab2_rx");

    // Saturation: 5 words into a 2-bit word counter.
    s_rxv = rxv_cnt[1];
    tx_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(w5[i]);
    frame_begin(1, 1'b0);
    for (int i = 0; i < 5; i++) spi_word(1'b0, 1'b1, 16, {16'h0, w5[i]}, r);
    frame_end(1);
    check("sat_wc", wc1, 3);
    check("sat_rxv_pulses", rxv_cnt[1] - s_rxv, 5);
    drain_rx("sat_rx");

    // WORD_W=8, mode 2.
    tx_q.delete();
    tx_q.push_back(16'h00C3);
    exp_q.push_back(16'h005A);
    frame_begin(2, 1'b1);
    spi_word(1'b1, 1'b0, 8, 32'h5A, r);
    frame_end(2);
    check("m2_miso_word", r, 32'hC3);
    check("m2_rx_data", rxd2, 8'h5A);
    drain_rx("m2_rx");

    // Second mode-2 frame, reset mid-word.
    tx_q.push_back(16'h0096);
    s_rxv = rxv_cnt[2]; s_abt = abt_cnt[2]; s_und = und_cnt[2];
    frame_begin(2, 1'b1);
    spi_word(1'b1, 1'b0, 4, 32'h9, r);
    check("rs_pre_active", act_v[2], 1);
    reset = 1'b1;
    #1;
    check("rs_miso", miso_v[2], 1);
    check("rs_oe", oe_v[2], 0);
    check("rs_rx_data", rxd2, 0);
    check("rs_active", act_v[2], 0);
    check("rs_wc", wc2, 0);
    check("rs_pulses", {txr_v[2], rxv_v[2], und_v[2], abt_v[2]}, 0);
    cs_n_v[2] = 1'b1;
    wait_clk(10);
    reset = 1'b0;
    wait_clk(10);
    check("rs_no_abort", abt_cnt[2] - s_abt, 0);
    check("rs_no_rxv", rxv_cnt[2] - s_rxv, 0);
    check("rs_no_underrun", und_cnt[2] - s_und, 0);
    check("rs_idle_active", act_v[2], 0);
    drain_rx("rs_rx");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_stream.md
Name: spi_slave_stream

Overview:
- Parametrised successor to the existing 16-bit SPI slave, clocked entirely in the `clk` domain.
- Oversamples `sck`, `cs_n` and `mosi` through synchronisers.
- Supports all four CPOL/CPHA modes, any word width, and back-to-back multi-word frames within one CS assertion.
- Exposes valid/ready-style word handshakes to the internal control/register logic that talks to the host MCU.

Parameters:
- WORD_W, 16: bits per SPI word, legal 4..32, shifted MSB first.
- CPOL, 0: idle level of `sck`.
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- SYNC_STAGES, 2: synchroniser depth for `sck`, `cs_n` and `mosi`, minimum 2.
- CNT_W, 8: width of the per-frame word counter; it saturates rather than wraps.

Ports:
- clk  in  1  system clock; must be at least 2*(SYNC_STAGES+2) × the `sck` frequency.
- reset  in  1  asynchronous, active-high reset.
- sck  in  1  SPI clock from the master, asynchronous.
- cs_n  in  1  chip select, active low, asynchronous.
- mosi  in  1  master-out data, asynchronous.
- miso  out  1  slave-out data; held at 1 while the frame is idle.
- miso_oe  out  1  tristate enable for the `miso` pad; 1 only while the frame is active.
- tx_data  in  WORD_W  next word to transmit.
- tx_valid  in  1  `tx_data` is valid.
- tx_ready  out  1  1-cycle pulse: `tx_data` was consumed this cycle.
- rx_data  out  WORD_W  last complete received word.
- rx_valid  out  1  1-cycle pulse: `rx_data` was updated.
- frame_active  out  1  `cs_n` (synchronised) is low.
- word_count  out  CNT_W  complete words received in the current frame.
- tx_underrun  out  1  1-cycle pulse: a load occurred with `tx_valid` low.
- frame_abort  out  1  1-cycle pulse: CS rose with a partial word shifted.

Behaviour:
Synchronisation:
- Each of `sck`, `cs_n` and `mosi` passes through SYNC_STAGES flops.
- Edges are detected by comparing the last two synchronised stages.
- A pin transition is therefore detected SYNC_STAGES+1 `clk` cycles later.

Edge decoding (`sck` edges are ignored unless `frame_active`=1):
- Leading edge = `sck` leaving CPOL; trailing edge = `sck` returning to CPOL.
- Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other one.

Reset (asynchronous, active-high): all state cleared.
- `miso`=1, `miso_oe`=0, `rx_data`=0.
- All pulse outputs 0.
- `word_count`=0, `frame_active`=0.
- Bit counter 0, rx/tx shift registers 0.
- The skip flag and the load-pending flag are both 0.

CS falling (frame start):
- `frame_active`=1, bit counter=0, `word_count`=0.
- A tx load is performed.

TX load (the same in both modes):
- If `tx_valid`=1: shift register <= `tx_data`, and `tx_ready` pulses.
- If `tx_valid`=0: shift register <= all ones, and `tx_underrun` pulses.

Outputs during a frame: `miso` = tx shift MSB and `miso_oe`=1 while `frame_active`.

Sample edge:
- rx shift <= {rx_shift[WORD_W-2:0], sync_mosi}; bit counter +1.
- When the counter reaches WORD_W, the word completes:
  - `rx_data` <= the completed word (including this bit), visible with `rx_valid`=1 in the next cycle.
  - Counter returns to 0; `word_count` +1, saturating at 2^CNT_W-1.
  - A tx load is scheduled per mode (below).

Shift edge, CPHA=0:
- If load-pending: perform a tx load instead of shifting, then clear load-pending.
- Otherwise: tx shift <= {tx_shift[WORD_W-2:0], 1}.
- Word completion sets load-pending.

Shift edge, CPHA=1:
- A tx load is performed at the word-completing sample edge itself.
- Every load (frame start or word boundary) sets the skip flag.
- The next shift edge clears the skip flag without shifting; otherwise it shifts as in CPHA=0.

CS rising:
- `frame_active`=0, `miso_oe`=0, `miso`=1.
- If bit counter ≠ 0: `frame_abort` pulses and the partial word is discarded (`rx_data` unchanged, no `rx_valid`).
- Counter, skip flag and load-pending cleared; `word_count` holds its value until the next CS falling.

Simultaneous events:
- CS edges take priority over `sck` edges detected in the same cycle.
- Reset asserted mid-frame aborts silently, with no pulses.

TX handshake timing:
- `tx_valid` is sampled only in the cycle of a load; the upstream side must present the next word before the word boundary.
- `tx_ready` and `tx_underrun` are mutually exclusive.

Decomposition:
- Package `spi_stream_pkg`: `sync_edge` port/struct typedef (`rise`, `fall`, `level`) and the constant `SPI_IDLE_FILL` (all ones).
- Sub-module `spi_sync_edge`: parametrised SYNC_STAGES synchroniser plus rise/fall detector, instantiated three times.

Test Plan:
- Mode 0, WORD_W=16: `tx_data`=16'h1234 with `tx_valid`=1; master sends 16'hA5C3 → `rx_data`=16'hA5C3 with one `rx_valid` pulse, master receives 16'h1234, `tx_ready` pulses once at CS fall.
- Mode 3 (CPOL=1, CPHA=1), 3-word frame: tx 16'h0001, 16'h8000, 16'hFFFE; master sends 16'h1111, 16'h2222, 16'h3333 → three `rx_valid` pulses in order, master receives the three tx words, `word_count`=3 after CS rise.
- Underrun: `tx_valid`=0 at CS fall, mode 1 → master reads 16'hFFFF, `tx_underrun` pulses once, `rx_data` still captured correctly.
- Abort: CS raised after 5 `sck` cycles → `frame_abort` pulse, no `rx_valid`, `rx_data` keeps its previous value; the next full frame works normally.
- WORD_W=8, mode 2: master sends 8'h5A → `rx_data`=8'h5A; async reset asserted mid-word of a second frame → all outputs return to reset values immediately, no pulses.
- Saturation, CNT_W=2: a 5-word frame leaves `word_count`=3, while `rx_valid` still pulses 5 times.
